// File: rtl/rpn_controller_if.sv
// Bundle of command-side and stack-side signals for the RPN command sequencer.
// The slave modport is the controller; the master modport is its environment
// (keypad decoder plus stack instance).
interface rpn_controller_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        stk_push;
    logic        stk_pop;
    logic        stk_write;
    logic [31:0] stk_value;
    logic [31:0] stk_top;
    logic [31:0] stk_next;
    logic [5:0]  stk_count;
    logic        stk_error;
    logic        done;
    logic        err_valid;
    logic [1:0]  err_code;
    logic [31:0] display;

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        input  stk_top, stk_next, stk_count, stk_error,
        output cmd_ready, stk_push, stk_pop, stk_write, stk_value,
        output done, err_valid, err_code, display
    );

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        output stk_top, stk_next, stk_count, stk_error,
        input  cmd_ready, stk_push, stk_pop, stk_write, stk_value,
        input  done, err_valid, err_code, display
    );
endinterface

// File: rtl/rpn_controller.sv
// RPN command sequencer: expands one calculator command into a sequence of
// push/pop/write strobes on the operand stack, computes arithmetic results
// from operands latched at accept, and reports completion or errors.
module rpn_controller #(
    parameter int DEPTH = 32
) (
    input logic            clock,
    input logic            reset,
    rpn_controller_if.slave bus
);

    localparam logic [2:0] OP_NUM   = 3'd0;
    localparam logic [2:0] OP_DUP   = 3'd1;
    localparam logic [2:0] OP_DROP  = 3'd2;
    localparam logic [2:0] OP_SWAP  = 3'd3;
    localparam logic [2:0] OP_ADD   = 3'd4;
    localparam logic [2:0] OP_SUB   = 3'd5;
    localparam logic [2:0] OP_MUL   = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_PUSH      = 4'd1;
    localparam logic [3:0] ST_POP       = 4'd2;
    localparam logic [3:0] ST_WRITE     = 4'd3;
    localparam logic [3:0] ST_SWAP_POP  = 4'd4;
    localparam logic [3:0] ST_SWAP_WR1  = 4'd5;
    localparam logic [3:0] ST_SWAP_PUSH = 4'd6;
    localparam logic [3:0] ST_SWAP_WR2  = 4'd7;
    localparam logic [3:0] ST_CLEAR     = 4'd8;

    localparam logic [1:0] ERR_UNDER = 2'd1;
    localparam logic [1:0] ERR_OVER  = 2'd2;
    localparam logic [1:0] ERR_FAULT = 2'd3;

    localparam logic [5:0] FULL = 6'(DEPTH);

    logic [3:0]  state;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] data_q;
    logic [2:0]  op_q;
    logic [5:0]  clr_left;
    logic [31:0] result;
    logic        done_q;
    logic        err_valid_q;
    logic [1:0]  err_code_q;

    assign bus.cmd_ready = (state == ST_IDLE);
    assign bus.display   = bus.stk_top;
    assign bus.done      = done_q;
    assign bus.err_valid = err_valid_q;
    assign bus.err_code  = err_code_q;

    // Arithmetic result from the operands captured at accept (a = next, b = top).
    always_comb begin
        result = 32'd0;
        case (op_q)
            OP_ADD:  result = opa + opb;
            OP_SUB:  result = opa - opb;
            OP_MUL:  result = opa * opb;
            default: result = 32'd0;
        endcase
    end

    // Moore strobe decode: each action state maps to exactly one stack strobe.
    always_comb begin
        bus.stk_push  = 1'b0;
        bus.stk_pop   = 1'b0;
        bus.stk_write = 1'b0;
        bus.stk_value = 32'd0;
        case (state)
            ST_PUSH, ST_SWAP_PUSH: bus.stk_push = 1'b1;
            ST_POP, ST_SWAP_POP, ST_CLEAR: bus.stk_pop = 1'b1;
            ST_WRITE: begin
                bus.stk_write = 1'b1;
                bus.stk_value = (op_q == OP_NUM) ? data_q : result;
            end
            ST_SWAP_WR1: begin
                bus.stk_write = 1'b1;
                bus.stk_value = opb;
            end
            ST_SWAP_WR2: begin
                bus.stk_write = 1'b1;
                bus.stk_value = opa;
            end
            default: ;
        endcase
    end

    // Command acceptance, legality checks, sequence stepping and status pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            opa         <= 32'd0;
            opb         <= 32'd0;
            data_q      <= 32'd0;
            op_q        <= 3'd0;
            clr_left    <= 6'd0;
            done_q      <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            done_q      <= 1'b0;
            err_valid_q <= 1'b0;
            if (state == ST_IDLE) begin
                if (bus.cmd_valid) begin
                    opa    <= bus.stk_next;
                    opb    <= bus.stk_top;
                    op_q   <= bus.cmd_op;
                    data_q <= bus.cmd_data;
                    case (bus.cmd_op)
                        OP_NUM: begin
                            if (bus.stk_count == FULL) begin
                                err_valid_q <= 1'b1;
                                err_code_q  <= ERR_OVER;
                            end else if (bus.stk_count == 6'd0) begin
                                state <= ST_WRITE;
                            end else begin
                                state <= ST_PUSH;
                            end
                        end
                        OP_DUP: begin
                            if (bus.stk_count == 6'd0) begin
                                err_valid_q <= 1'b1;
                                err_code_q  <= ERR_UNDER;
                            end else if (bus.stk_count == FULL) begin
                                err_valid_q <= 1'b1;
                                err_code_q  <= ERR_OVER;
                            end else begin
                                state <= ST_PUSH;
                            end
                        end
                        OP_DROP: begin
                            if (bus.stk_count == 6'd0) begin
                                err_valid_q <= 1'b1;
                                err_code_q  <= ERR_UNDER;
                            end else begin
                                state <= ST_POP;
                            end
                        end
                        OP_ADD, OP_SUB, OP_MUL: begin
                            if (bus.stk_count < 6'd2) begin
                                err_valid_q <= 1'b1;
                                err_code_q  <= ERR_UNDER;
                            end else begin
                                state <= ST_POP;
                            end
                        end
                        OP_SWAP: begin
                            if (bus.stk_count < 6'd2) begin
                                err_valid_q <= 1'b1;
                                err_code_q  <= ERR_UNDER;
                            end else begin
                                state <= ST_SWAP_POP;
                            end
                        end
                        default: begin
                            if (bus.stk_count == 6'd0) begin
                                done_q <= 1'b1;
                            end else begin
                                clr_left <= bus.stk_count;
                                state    <= ST_CLEAR;
                            end
                        end
                    endcase
                end
            end else if (bus.stk_error) begin
                state       <= ST_IDLE;
                err_valid_q <= 1'b1;
                err_code_q  <= ERR_FAULT;
            end else begin
                case (state)
                    ST_PUSH: begin
                        if (op_q == OP_NUM) begin
                            state <= ST_WRITE;
                        end else begin
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                        end
                    end
                    ST_POP: begin
                        if (op_q == OP_DROP) begin
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                        end else begin
                            state <= ST_WRITE;
                        end
                    end
                    ST_WRITE: begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                    end
                    ST_SWAP_POP:  state <= ST_SWAP_WR1;
                    ST_SWAP_WR1:  state <= ST_SWAP_PUSH;
                    ST_SWAP_PUSH: state <= ST_SWAP_WR2;
                    ST_SWAP_WR2: begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                    end
                    ST_CLEAR: begin
                        clr_left <= clr_left - 6'd1;
                        if (clr_left == 6'd1) begin
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rpn_controller.sv
// Bench for rpn_controller: a behavioural stack drives the stack inputs, an RPN
// reference model predicts each command's outcome into a scoreboard queue, and
// a monitor pops and compares whenever done or err_valid pulses.
module tb_rpn_controller;

    localparam int DEPTH = 32;

    typedef struct {
        bit          is_err;
        logic [1:0]  code;
        int          lat;
        int          accept_cyc;
        string       seq;
        bit          chk_stack;
        logic [31:0] top;
        logic [31:0] nxt;
        int          cnt;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    exp_t        sbq[$];
    logic [31:0] rs[$];
    string       acc = "";

    logic [31:0] stack_mem [0:DEPTH-1];
    logic [5:0]  stack_cnt = 6'd0;

    rpn_controller_if bus ();

    rpn_controller #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Cycle index used to measure command latency.
    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural operand stack obeying the push/pop/write contract.
    always @(posedge clock) begin
        if (bus.stk_push) begin
            for (int i = 1; i < DEPTH; i++) stack_mem[i] <= stack_mem[i-1];
            stack_cnt <= stack_cnt + 6'd1;
        end else if (bus.stk_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) stack_mem[i] <= stack_mem[i+1];
            stack_mem[DEPTH-1] <= 32'd0;
            stack_cnt <= stack_cnt - 6'd1;
        end else if (bus.stk_write) begin
            stack_mem[0] <= bus.stk_value;
            if (stack_cnt == 6'd0) stack_cnt <= 6'd1;
        end
    end

    assign bus.stk_top   = (stack_cnt > 6'd0) ? stack_mem[0] : 32'd0;
    assign bus.stk_next  = (stack_cnt > 6'd1) ? stack_mem[1] : 32'd0;
    assign bus.stk_count = stack_cnt;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic checkSeq(input string actual, input string expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL strobe_seq: got \"%s\", want \"%s\"", actual, expected);
        end
    endtask

    // RPN reference: operates on a queue whose front is the top of stack.
    task automatic model_cmd(input logic [2:0] op, input logic [31:0] d, output exp_t e);
        int          n;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
        n = rs.size();
        e.is_err = 1'b0; e.code = 2'd0; e.lat = 1; e.accept_cyc = 0;
        e.seq = ""; e.chk_stack = 1'b1;
        case (op)
            3'd0: begin
                if (n == DEPTH) begin e.is_err = 1; e.code = 2; end
                else if (n == 0) begin
                    rs.push_front(d); e.seq = $sformatf("w%0h ", d); e.lat = 2;
                end else begin
                    rs.push_front(d); e.seq = $sformatf("u w%0h ", d); e.lat = 3;
                end
            end
            3'd1: begin
                if (n == 0) begin e.is_err = 1; e.code = 1; end
                else if (n == DEPTH) begin e.is_err = 1; e.code = 2; end
                else begin rs.push_front(rs[0]); e.seq = "u "; e.lat = 2; end
            end
            3'd2: begin
                if (n == 0) begin e.is_err = 1; e.code = 1; end
                else begin void'(rs.pop_front()); e.seq = "o "; e.lat = 2; end
            end
            3'd3: begin
                if (n < 2) begin e.is_err = 1; e.code = 1; end
                else begin
                    b = rs.pop_front(); a = rs.pop_front();
                    rs.push_front(b); rs.push_front(a);
                    e.seq = $sformatf("o w%0h u w%0h ", b, a); e.lat = 5;
                end
            end
            3'd7: begin
                for (int i = 0; i < n; i++) e.seq = {e.seq, "o "};
                e.lat = n + 1;
                rs.delete();
            end
            default: begin
                if (n < 2) begin e.is_err = 1; e.code = 1; end
                else begin
                    b = rs.pop_front(); a = rs.pop_front();
                    p = 64'(a) * 64'(b);
                    if (op == 3'd4) a = a + b;
                    else if (op == 3'd5) a = a - b;
                    else a = p[31:0];
                    rs.push_front(a);
                    e.seq = $sformatf("o w%0h ", a); e.lat = 3;
                end
            end
        endcase
        e.top = (rs.size() > 0) ? rs[0] : 32'd0;
        e.nxt = (rs.size() > 1) ? rs[1] : 32'd0;
        e.cnt = rs.size();
    endtask

    // Rebuild the reference after a sequence was deliberately cut short.
    task automatic resync();
        rs.delete();
        for (int i = 0; i < int'(stack_cnt); i++) rs.push_back(stack_mem[i]);
    endtask

    // Waits for cmd_ready, presents one command for one accept edge, returns T.
    task automatic issueRaw(input logic [2:0] op, input logic [31:0] d, input bit predict, output int t, output bit ok);
        exp_t e;
        int   waited;
        waited = 0;
        ok = 1'b1;
        @(negedge clock);
        while (!bus.cmd_ready && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        if (!bus.cmd_ready) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL cmd_ready_timeout: got 0, want 1 within 100 cycles");
            ok = 1'b0;
            t = cyc;
            return;
        end
        t = cyc;
        if (predict) begin
            model_cmd(op, d, e);
            e.accept_cyc = t;
            sbq.push_back(e);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'($urandom_range(0, 7));
        bus.cmd_data  = $urandom;
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] d);
        int t;
        bit ok;
        issueRaw(op, d, 1'b1, t, ok);
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        @(negedge clock);
        while ((sbq.size() != 0 || !bus.cmd_ready) && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        if (sbq.size() != 0 || !bus.cmd_ready) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain_timeout: got %0d pending, want 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic checkIdleQuiet(input string tag);
        checkOutput({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        checkOutput({tag, "_strobes"}, {29'd0, bus.stk_push, bus.stk_pop, bus.stk_write}, 32'd0);
        checkOutput({tag, "_done"}, 32'(bus.done), 32'd0);
        checkOutput({tag, "_err_valid"}, 32'(bus.err_valid), 32'd0);
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        checkIdleQuiet("reset");
        checkOutput("reset_err_code", 32'(bus.err_code), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Scoreboard monitor: collects strobes and compares on every done/err_valid.
    initial begin
        exp_t e;
        int   n;
        forever begin
            @(negedge clock);
            if (reset) begin
                acc = "";
            end else begin
                n = int'(bus.stk_push) + int'(bus.stk_pop) + int'(bus.stk_write);
                if (n > 1) begin
                    miscompares++;
                    $display("[TB] FAIL strobe_onehot: got %0d strobes, want at most 1", n);
                end
                if (bus.stk_push)  acc = {acc, "u "};
                if (bus.stk_pop)   acc = {acc, "o "};
                if (bus.stk_write) acc = {acc, $sformatf("w%0h ", bus.stk_value)};
                if (bus.done || bus.err_valid) begin
                    if (sbq.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL unexpected_event: got done=%0d err_valid=%0d, want none", bus.done, bus.err_valid);
                    end else begin
                        e = sbq.pop_front();
                        checkOutput("event_kind", {30'd0, bus.err_valid, bus.done}, e.is_err ? 32'd2 : 32'd1);
                        if (e.is_err) checkOutput("err_code", 32'(bus.err_code), 32'(e.code));
                        checkOutput("latency", 32'(cyc - e.accept_cyc), 32'(e.lat));
                        checkSeq(acc, e.seq);
                        if (e.chk_stack) begin
                            checkOutput("display", bus.display, e.top);
                            checkOutput("stack_next", bus.stk_next, e.nxt);
                            checkOutput("stack_count", 32'(bus.stk_count), 32'(e.cnt));
                        end
                    end
                    acc = "";
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   t;
        bit   ok;
        exp_t e;
        int   r;
        logic [31:0] d;

        for (int i = 0; i < DEPTH; i++) stack_mem[i] = 32'd0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_data  = 32'd0;
        bus.stk_error = 1'b0;
        doReset();

        applyStimulus(3'd0, 32'd1);
        applyStimulus(3'd0, 32'd2);
        applyStimulus(3'd4, 32'd0);
        applyStimulus(3'd0, 32'd10);
        applyStimulus(3'd0, 32'd3);
        applyStimulus(3'd5, 32'd0);
        applyStimulus(3'd0, 32'd0);
        applyStimulus(3'd3, 32'd0);
        applyStimulus(3'd5, 32'd0);
        applyStimulus(3'd0, 32'd5);
        applyStimulus(3'd0, 32'd9);
        applyStimulus(3'd3, 32'd0);

        applyStimulus(3'd7, 32'd0);
        drain();
        doReset();
        applyStimulus(3'd4, 32'd0);
        applyStimulus(3'd2, 32'd0);
        applyStimulus(3'd1, 32'd0);
        applyStimulus(3'd7, 32'd0);

        for (int i = 0; i < DEPTH; i++) applyStimulus(3'd0, $urandom);
        applyStimulus(3'd0, 32'd7);
        applyStimulus(3'd1, 32'd0);
        applyStimulus(3'd7, 32'd0);

        applyStimulus(3'd0, 32'h0001_0000);
        applyStimulus(3'd0, 32'h0001_0000);
        applyStimulus(3'd6, 32'd0);

        applyStimulus(3'd0, 32'd11);
        applyStimulus(3'd0, 32'd22);
        drain();
        issueRaw(3'd3, 32'd0, 1'b0, t, ok);
        if (ok) begin
            e.is_err = 1'b1; e.code = 2'd3; e.lat = 2; e.accept_cyc = t;
            e.seq = "o "; e.chk_stack = 1'b0; e.top = 32'd0; e.nxt = 32'd0; e.cnt = 0;
            sbq.push_back(e);
            bus.stk_error = 1'b1;
            @(posedge clock);
            #1;
            bus.stk_error = 1'b0;
        end
        drain();
        resync();

        issueRaw(3'd0, 32'd5, 1'b0, t, ok);
        if (ok) begin
            @(posedge clock);
            #1;
            reset = 1'b1;
            @(posedge clock);
            #1;
            reset = 1'b0;
            @(negedge clock);
            checkIdleQuiet("midseq_reset");
            checkOutput("midseq_reset_err_code", 32'(bus.err_code), 32'd0);
            repeat (4) @(negedge clock);
        end
        resync();

        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            d = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 20)) : $urandom;
            if (r < 40)      applyStimulus(3'd0, d);
            else if (r < 50) applyStimulus(3'd1, d);
            else if (r < 60) applyStimulus(3'd2, d);
            else if (r < 68) applyStimulus(3'd3, d);
            else if (r < 76) applyStimulus(3'd4, d);
            else if (r < 84) applyStimulus(3'd5, d);
            else if (r < 97) applyStimulus(3'd6, d);
            else             applyStimulus(3'd7, d);
        end
        drain();
        repeat (3) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
